hdmi_mode_controller: RTL and testbench
=======================================

Name: hdmi_mode_controller

Overview:
- Sequences the HDMI timing generator.
- Selects the active video mode (480p, 768p or 1080p) from a debounced switch request.
- Drives the generator's 12-bit timing registers and pixel-clock mux select.
- Gates the generator's start so a mode change happens only at a frame boundary and only after the pixel PLL reports stable lock.
- Sits between board switches/PLL and the timing generator in the HDMI output path.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive identical synchronized samples required to accept a switch request.
- SETTLE_CYCLES, 8: consecutive cycles pll_locked must stay high before start is asserted.
- DRAIN_TIMEOUT, 1048575: maximum cycles to wait for frame_end before forcing a mode change.
- COUNT_WIDTH, 20: width of the shared internal counter; must hold DRAIN_TIMEOUT.

Ports:
- clock, input, 1: single system clock.
- reset, input, 1: asynchronous, active-high reset.
- switch, input, 2: requested mode, asynchronous. 0=480p, 1=768p, 2=1080p, 3=invalid.
- pll_locked, input, 1: pixel PLL lock, asynchronous; double-synchronized internally.
- frame_end, input, 1: one-cycle pulse from the generator at the end of its last line; already in the clock domain.
- start, output, 1: run enable to the timing generator.
- clock_select, output, 2: pixel-clock mux select; equals the mode code.
- hor_total, hor_sync_len, hor_back_porch, hor_resolution, hor_front_porch, output, 12 each: horizontal timing.
- ver_total, ver_sync_len, ver_back_porch, ver_resolution, ver_front_porch, output, 12 each: vertical timing.
- current_mode, output, 2: mode currently loaded.
- busy, output, 1: high in every state except RUN.

Behaviour:
- Reset values:
  - start=0, clock_select=0, current_mode=0, busy=1.
  - Timing outputs hold the 480p set: 800/96/48/640/16 and 525/2/33/480/10.
  - State=LOAD, pending=0, counter=0.
- Mode table (total/sync/bp/res/fp):
  - 480p: H 800/96/48/640/16; V 525/2/33/480/10.
  - 768p: H 1344/136/160/1024/24; V 806/6/29/768/3.
  - 1080p: H 2200/44/148/1920/88; V 1125/5/36/1080/4.
- Request path:
  - switch passes through a 2-flop synchronizer.
  - A value is accepted after DEBOUNCE_CYCLES consecutive equal samples.
  - An accepted value of 3 is ignored.
  - An accepted valid value that differs from current_mode sets pending_mode and the pending flag.
  - A later accepted value overwrites pending_mode.
  - An accepted value equal to current_mode clears pending.
- State machine:
  - LOAD (1 cycle): start=0. Latch the timing set and clock_select from the target mode: pending_mode if pending is set, otherwise current_mode. current_mode=target; clear pending; counter=0; go to WAIT_LOCK.
  - WAIT_LOCK: start=0. Counter increments while synced pll_locked=1 and clears to 0 when it is 0. When counter reaches SETTLE_CYCLES-1 with lock still high, go to RUN. Outputs become visible the cycle after entry.
  - RUN: start=1, busy=0.
    - Synced pll_locked=0 → go to WAIT_LOCK and drop start next cycle.
    - Otherwise, pending set → go to DRAIN with counter=0.
  - DRAIN: start stays 1.
    - frame_end=1 → go to LOAD.
    - Counter reaching DRAIN_TIMEOUT → go to LOAD.
    - Synced pll_locked=0 → go to LOAD immediately. This takes priority over frame_end.
- start falls in the first LOAD cycle. The new timing appears one cycle later, so the generator never runs with mixed timing.
- A request that arrives during LOAD or WAIT_LOCK is held pending and applied on the next RUN→DRAIN pass.
- An asynchronous reset mid-sequence returns to the reset values at once, whatever the state.
- Counter saturates; no wrap-around.

Decomposition:
- Package hdmi_timing_pkg holds:
  - mode codes MODE_480P=0, MODE_768P=1, MODE_1080P=2;
  - the 30 timing constants;
  - the state encoding.
- Sub-module mode_request_sync: synchronizer plus debounce counter. It emits a one-cycle accepted pulse with a 2-bit value.

Test Plan:
- Reset release with pll_locked=1 → start rises 1 (LOAD) + 8 (WAIT_LOCK) + sync latency after release; hor_total=800; current_mode=0.
- switch=2 held for 20 cycles in RUN, frame_end pulse 100 cycles later → start falls the cycle after frame_end; hor_total=2200, ver_total=1125, clock_select=2; start re-rises 8 locked cycles later.
- switch toggles 1/0 every 5 cycles → no request is accepted; busy stays 0; current_mode=0.
- Request 1, then no frame_end → forced LOAD after 1048575 DRAIN cycles; current_mode=1; hor_total=1344.
- pll_locked drops for 3 cycles in RUN → start=0; start returns only after 8 consecutive locked cycles; mode unchanged.
- switch=3 held stable → ignored. Reset asserted during WAIT_LOCK in 1080p → all outputs return to 480p reset values immediately.

Source files
------------

// File: rtl/hdmi_timing_pkg.sv
// Mode codes, per-mode video timing constants and controller state encoding
// shared by the HDMI mode controller and its request synchronizer.
package hdmi_timing_pkg;

    localparam logic [1:0] MODE_480P    = 2'd0;
    localparam logic [1:0] MODE_768P    = 2'd1;
    localparam logic [1:0] MODE_1080P   = 2'd2;
    localparam logic [1:0] MODE_INVALID = 2'd3;

    localparam logic [11:0] H480_TOTAL  = 12'd800;
    localparam logic [11:0] H480_SYNC   = 12'd96;
    localparam logic [11:0] H480_BP     = 12'd48;
    localparam logic [11:0] H480_RES    = 12'd640;
    localparam logic [11:0] H480_FP     = 12'd16;
    localparam logic [11:0] V480_TOTAL  = 12'd525;
    localparam logic [11:0] V480_SYNC   = 12'd2;
    localparam logic [11:0] V480_BP     = 12'd33;
    localparam logic [11:0] V480_RES    = 12'd480;
    localparam logic [11:0] V480_FP     = 12'd10;

    localparam logic [11:0] H768_TOTAL  = 12'd1344;
    localparam logic [11:0] H768_SYNC   = 12'd136;
    localparam logic [11:0] H768_BP     = 12'd160;
    localparam logic [11:0] H768_RES    = 12'd1024;
    localparam logic [11:0] H768_FP     = 12'd24;
    localparam logic [11:0] V768_TOTAL  = 12'd806;
    localparam logic [11:0] V768_SYNC   = 12'd6;
    localparam logic [11:0] V768_BP     = 12'd29;
    localparam logic [11:0] V768_RES    = 12'd768;
    localparam logic [11:0] V768_FP     = 12'd3;

    localparam logic [11:0] H1080_TOTAL = 12'd2200;
    localparam logic [11:0] H1080_SYNC  = 12'd44;
    localparam logic [11:0] H1080_BP    = 12'd148;
    localparam logic [11:0] H1080_RES   = 12'd1920;
    localparam logic [11:0] H1080_FP    = 12'd88;
    localparam logic [11:0] V1080_TOTAL = 12'd1125;
    localparam logic [11:0] V1080_SYNC  = 12'd5;
    localparam logic [11:0] V1080_BP    = 12'd36;
    localparam logic [11:0] V1080_RES   = 12'd1080;
    localparam logic [11:0] V1080_FP    = 12'd4;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WAIT_LOCK,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_bp;
        logic [11:0] h_res;
        logic [11:0] h_fp;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_bp;
        logic [11:0] v_res;
        logic [11:0] v_fp;
    } timing_t;

    function automatic timing_t mode_timing(input logic [1:0] mode);
        timing_t t;
        case (mode)
            MODE_768P: t = '{H768_TOTAL, H768_SYNC, H768_BP, H768_RES,
                             H768_FP, V768_TOTAL, V768_SYNC, V768_BP,
                             V768_RES, V768_FP};
            MODE_1080P: t = '{H1080_TOTAL, H1080_SYNC, H1080_BP,
                              H1080_RES, H1080_FP, V1080_TOTAL,
                              V1080_SYNC, V1080_BP, V1080_RES,
                              V1080_FP};
            default: t = '{H480_TOTAL, H480_SYNC, H480_BP, H480_RES,
                           H480_FP, V480_TOTAL, V480_SYNC, V480_BP,
                           V480_RES, V480_FP};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mode_request_sync.sv
// Two-flop synchronizer and debounce for the mode switch; emits a single
// accepted pulse once the synchronized value has been stable long enough.
module mode_request_sync
    import hdmi_timing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [1:0] i_switch,
    output logic       o_accept,
    output logic [1:0] o_mode
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    r_meta;
    logic [1:0]    r_sync;
    logic [1:0]    r_last;
    logic [CW-1:0] r_count;
    logic          r_accept;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_meta   <= MODE_480P;
            r_sync   <= MODE_480P;
            r_last   <= MODE_480P;
            r_count  <= '0;
            r_accept <= 1'b0;
        end else begin
            r_meta   <= i_switch;
            r_sync   <= r_meta;
            r_accept <= 1'b0;
            if (r_sync != r_last) begin
                r_last  <= r_sync;
                r_count <= CW'(1);
            end else if (r_count != C_FULL) begin
                // Count saturates so a held value is accepted only once
                r_count  <= r_count + 1'b1;
                r_accept <= (r_count == C_LAST);
            end
        end
    end

    assign o_accept = r_accept;
    assign o_mode   = r_last;

endmodule

// File: rtl/hdmi_mode_controller.sv
// Sequences the HDMI timing generator: mode selection, timing register load,
// PLL lock settling and frame-aligned mode changes.
module hdmi_mode_controller
    import hdmi_timing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 8,
    parameter int DRAIN_TIMEOUT   = 1048575,
    parameter int COUNT_WIDTH     = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  switch,
    input  logic        pll_locked,
    input  logic        frame_end,
    output logic        start,
    output logic [1:0]  clock_select,
    output logic [11:0] hor_total,
    output logic [11:0] hor_sync_len,
    output logic [11:0] hor_back_porch,
    output logic [11:0] hor_resolution,
    output logic [11:0] hor_front_porch,
    output logic [11:0] ver_total,
    output logic [11:0] ver_sync_len,
    output logic [11:0] ver_back_porch,
    output logic [11:0] ver_resolution,
    output logic [11:0] ver_front_porch,
    output logic [1:0]  current_mode,
    output logic        busy
);

    localparam logic [COUNT_WIDTH-1:0] C_SETTLE_LAST =
        COUNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] C_DRAIN_MAX =
        COUNT_WIDTH'(DRAIN_TIMEOUT);

    logic                   r_lock_meta;
    logic                   r_lock_sync;
    logic                   w_accept;
    logic [1:0]             w_accept_mode;
    logic [1:0]             w_target;
    logic [1:0]             w_ref_mode;
    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_pending;
    logic [1:0]             r_pending_mode;
    logic [1:0]             r_mode;
    logic [1:0]             r_clock_select;
    timing_t                r_timing;
    logic                   r_start;
    logic                   r_busy;

    mode_request_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_req (
        .i_clock (clock),
        .i_reset (reset),
        .i_switch(switch),
        .o_accept(w_accept),
        .o_mode  (w_accept_mode)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    assign w_target   = r_pending ? r_pending_mode : r_mode;
    // During LOAD the mode being installed is what a new request competes with
    assign w_ref_mode = (r_state == ST_LOAD) ? w_target : r_mode;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_LOAD;
            r_count        <= '0;
            r_pending      <= 1'b0;
            r_pending_mode <= MODE_480P;
            r_mode         <= MODE_480P;
            r_clock_select <= MODE_480P;
            r_timing       <= mode_timing(MODE_480P);
            r_start        <= 1'b0;
            r_busy         <= 1'b1;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    r_timing       <= mode_timing(w_target);
                    r_clock_select <= w_target;
                    r_mode         <= w_target;
                    r_pending      <= 1'b0;
                    r_count        <= '0;
                    r_start        <= 1'b0;
                    r_busy         <= 1'b1;
                    r_state        <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (!r_lock_sync) begin
                        r_count <= '0;
                    end else if (r_count == C_SETTLE_LAST) begin
                        r_start <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_RUN;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!r_lock_sync) begin
                        r_count <= '0;
                        r_start <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_WAIT_LOCK;
                    end else if (r_pending) begin
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!r_lock_sync || frame_end ||
                        r_count >= C_DRAIN_MAX) begin
                        r_start <= 1'b0;
                        r_state <= ST_LOAD;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase

            if (w_accept && w_accept_mode != MODE_INVALID) begin
                if (w_accept_mode == w_ref_mode) begin
                    r_pending <= 1'b0;
                end else begin
                    r_pending      <= 1'b1;
                    r_pending_mode <= w_accept_mode;
                end
            end
        end
    end

    assign start           = r_start;
    assign busy            = r_busy;
    assign current_mode    = r_mode;
    assign clock_select    = r_clock_select;
    assign hor_total       = r_timing.h_total;
    assign hor_sync_len    = r_timing.h_sync;
    assign hor_back_porch  = r_timing.h_bp;
    assign hor_resolution  = r_timing.h_res;
    assign hor_front_porch = r_timing.h_fp;
    assign ver_total       = r_timing.v_total;
    assign ver_sync_len    = r_timing.v_sync;
    assign ver_back_porch  = r_timing.v_bp;
    assign ver_resolution  = r_timing.v_res;
    assign ver_front_porch = r_timing.v_fp;

endmodule

// File: tb/tb_hdmi_mode_controller.sv
// Directed bench for hdmi_mode_controller; the drain timeout is shortened
// so the forced-change path completes in a short run.
module tb_hdmi_mode_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  switch = 2'd0;
    logic        pll_locked = 1'b1;
    logic        frame_end = 1'b0;
    logic        start;
    logic [1:0]  clock_select;
    logic [11:0] hor_total, hor_sync_len, hor_back_porch;
    logic [11:0] hor_resolution, hor_front_porch;
    logic [11:0] ver_total, ver_sync_len, ver_back_porch;
    logic [11:0] ver_resolution, ver_front_porch;
    logic [1:0]  current_mode;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n;

    hdmi_mode_controller #(
        .DRAIN_TIMEOUT(300)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .switch         (switch),
        .pll_locked     (pll_locked),
        .frame_end      (frame_end),
        .start          (start),
        .clock_select   (clock_select),
        .hor_total      (hor_total),
        .hor_sync_len   (hor_sync_len),
        .hor_back_porch (hor_back_porch),
        .hor_resolution (hor_resolution),
        .hor_front_porch(hor_front_porch),
        .ver_total      (ver_total),
        .ver_sync_len   (ver_sync_len),
        .ver_back_porch (ver_back_porch),
        .ver_resolution (ver_resolution),
        .ver_front_porch(ver_front_porch),
        .current_mode   (current_mode),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic tick(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        tick(2);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 1);
        chk("rst_htotal", hor_total, 800);
        chk("rst_vtotal", ver_total, 525);
        chk("rst_mode", current_mode, 0);
        chk("rst_clksel", clock_select, 0);

        reset = 1'b0;
        tick(9);
        chk("boot_start_low", start, 0);
        tick(1);
        chk("boot_start_high", start, 1);
        chk("boot_busy", busy, 0);
        chk("boot_htotal", hor_total, 800);
        chk("boot_hfp", hor_front_porch, 16);
        chk("boot_vfp", ver_front_porch, 10);
        chk("boot_mode", current_mode, 0);

        switch = 2'd2;
        tick(30);
        chk("req_busy", busy, 1);
        chk("drain_start", start, 1);
        chk("drain_htotal", hor_total, 800);
        chk("drain_mode", current_mode, 0);
        tick(100);
        chk("drain_hold", start, 1);
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        chk("fe_start_low", start, 0);
        tick(1);
        chk("m2_htotal", hor_total, 2200);
        chk("m2_vtotal", ver_total, 1125);
        chk("m2_hsync", hor_sync_len, 44);
        chk("m2_vres", ver_resolution, 1080);
        chk("m2_clksel", clock_select, 2);
        chk("m2_mode", current_mode, 2);
        tick(7);
        chk("m2_settle_low", start, 0);
        tick(1);
        chk("m2_start", start, 1);
        chk("m2_busy", busy, 0);

        for (int i = 0; i < 12; i++) begin
            switch = (i % 2 == 0) ? 2'd1 : 2'd0;
            tick(5);
            chk("toggle_busy", busy, 0);
        end
        switch = 2'd2;
        tick(30);
        chk("toggle_end_busy", busy, 0);
        chk("toggle_mode", current_mode, 2);

        switch = 2'd1;
        n = 0;
        while (!busy && n < 50) begin
            tick(1);
            n++;
        end
        chk("to_req_busy", busy, 1);
        n = 0;
        while (start && n < 400) begin
            tick(1);
            n++;
        end
        chk("to_cycles", n, 301);
        tick(1);
        chk("to_htotal", hor_total, 1344);
        chk("to_vtotal", ver_total, 806);
        chk("to_hbp", hor_back_porch, 160);
        chk("to_mode", current_mode, 1);
        chk("to_clksel", clock_select, 1);
        tick(8);
        chk("to_start", start, 1);

        pll_locked = 1'b0;
        tick(3);
        chk("unlock_start", start, 0);
        chk("unlock_busy", busy, 1);
        pll_locked = 1'b1;
        tick(9);
        chk("relock_low", start, 0);
        tick(1);
        chk("relock_start", start, 1);
        chk("relock_mode", current_mode, 1);
        chk("relock_htotal", hor_total, 1344);

        switch = 2'd3;
        tick(40);
        chk("inv_busy", busy, 0);
        chk("inv_mode", current_mode, 1);

        switch = 2'd2;
        n = 0;
        while (!busy && n < 50) begin
            tick(1);
            n++;
        end
        chk("r6_busy", busy, 1);
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        tick(1);
        chk("r6_htotal", hor_total, 2200);
        chk("r6_mode", current_mode, 2);
        tick(3);
        chk("r6_waitlock", start, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_start", start, 0);
        chk("ar_busy", busy, 1);
        chk("ar_mode", current_mode, 0);
        chk("ar_clksel", clock_select, 0);
        chk("ar_htotal", hor_total, 800);
        chk("ar_hsync", hor_sync_len, 96);
        chk("ar_hbp", hor_back_porch, 48);
        chk("ar_hres", hor_resolution, 640);
        chk("ar_vtotal", ver_total, 525);
        chk("ar_vsync", ver_sync_len, 2);
        chk("ar_vbp", ver_back_porch, 33);
        chk("ar_vres", ver_resolution, 480);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
